// File: rtl/master_circuit_if.sv
// rtl/master_circuit_if.sv - register-file/compare bus between master_circuit and the slave
//
// Purpose : groups the slave-facing signals so the master and slave each see one
//           modport instead of three loose buses.
// Signals :
//   sel[5:0] : [1:0] mux-A register index, [3:2] mux-B register index,
//              [5:4] load-source index
//   ld[3:0]  : one-hot slave register load strobes
//   lt[2:0]  : slave compare result A vs B: [0] A<B, [1] A==B, [2] A>B
//              (combinational from sel on the slave side)
interface master_circuit_if;
    logic [5:0] sel;
    logic [3:0] ld;
    logic [2:0] lt;

    modport master (
        output sel,
        output ld,
        input  lt
    );

    modport slave (
        input  sel,
        input  ld,
        output lt
    );
endinterface

// File: rtl/master_circuit.sv
// rtl/master_circuit.sv - initiator that loads four slave registers and finds max/min indices
//
// Purpose : loads the four 4-bit slave registers, then walks the slave comparator
//           twice (once tracking the largest, once the smallest value) and reports
//           the winning register indices.
// Parameter:
//   SETTLE      : cycles each compare pattern is held before lt is sampled (1..15)
// Ports :
//   clk_i       : system clock, rising edge
//   rst_n_i     : asynchronous active-low reset
//   start_i     : level, sampled in IDLE only; begins a run
//   skip_load_i : sampled with start_i; 1 = compare the values already held
//   slv_bus     : master modport of master_circuit_if (sel, ld out; lt in)
//   busy_o      : high while a run is in LOAD or compare states
//   done_o      : one-cycle pulse when max_idx_o/min_idx_o are fresh
//   max_idx_o   : index of the largest value, held until the next done
//   min_idx_o   : index of the smallest value, held until the next done
//   err_o       : sticky flag, a sampled lt was not one-hot; cleared on next start
module master_circuit #(
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  skip_load_i,
    master_circuit_if.master      slv_bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            max_idx_o,
    output logic [1:0]            min_idx_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMP_MAX,
        S_CMP_MIN,
        S_FINISH
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_q,    state_d;
    logic [1:0]  step_q,     step_d;
    logic [3:0]  settle_q,   settle_d;
    logic [1:0]  cand_max_q, cand_max_d;
    logic [1:0]  cand_min_q, cand_min_d;
    logic        err_q,      err_d;
    logic [5:0]  sel_q,      sel_d;
    logic [3:0]  ld_q,       ld_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic [1:0]  max_idx_q,  max_idx_d;
    logic [1:0]  min_idx_q,  min_idx_d;

    logic        lt_onehot;
    logic        step_last;

    assign lt_onehot = (slv_bus.lt == 3'b001) || (slv_bus.lt == 3'b010) ||
                       (slv_bus.lt == 3'b100);
    assign step_last = (settle_q == SETTLE_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            step_q     <= 2'd0;
            settle_q   <= 4'd0;
            cand_max_q <= 2'd0;
            cand_min_q <= 2'd0;
            err_q      <= 1'b0;
            sel_q      <= 6'd0;
            ld_q       <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            max_idx_q  <= 2'd0;
            min_idx_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            settle_q   <= settle_d;
            cand_max_q <= cand_max_d;
            cand_min_q <= cand_min_d;
            err_q      <= err_d;
            sel_q      <= sel_d;
            ld_q       <= ld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            max_idx_q  <= max_idx_d;
            min_idx_q  <= min_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        settle_d   = settle_q;
        cand_max_d = cand_max_q;
        cand_min_d = cand_min_q;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d      = 1'b0;
                    cand_max_d = 2'd0;
                    cand_min_d = 2'd0;
                    settle_d   = 4'd0;
                    // Register 0 is the initial candidate, so compares start at index 1.
                    if (skip_load_i) begin
                        state_d = S_CMP_MAX;
                        step_d  = 2'd1;
                    end else begin
                        state_d = S_LOAD;
                        step_d  = 2'd0;
                    end
                end
            end

            S_LOAD: begin
                if (step_q == 2'd3) begin
                    state_d  = S_CMP_MAX;
                    step_d   = 2'd1;
                    settle_d = 4'd0;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end

            S_CMP_MAX, S_CMP_MIN: begin
                if (step_last) begin
                    settle_d = 4'd0;
                    // A malformed compare result flags an error but leaves the
                    // candidate alone; strict > / < keeps the lower index on ties.
                    if (!lt_onehot) begin
                        err_d = 1'b1;
                    end else if (state_q == S_CMP_MAX) begin
                        if (slv_bus.lt[2]) cand_max_d = step_q;
                    end else begin
                        if (slv_bus.lt[0]) cand_min_d = step_q;
                    end

                    if (step_q == 2'd3) begin
                        step_d  = 2'd1;
                        state_d = (state_q == S_CMP_MAX) ? S_CMP_MIN : S_FINISH;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so every output
    // lines up with the state it belongs to and nothing from lt reaches a pin
    // without passing through a flop.
    always_comb begin
        sel_d     = 6'd0;
        ld_d      = 4'd0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;

        unique case (state_d)
            S_LOAD: begin
                sel_d  = {step_d, 4'b0000};
                ld_d   = 4'b0001 << step_d;
                busy_d = 1'b1;
            end
            S_CMP_MAX: begin
                sel_d  = {2'b00, cand_max_d, step_d};
                busy_d = 1'b1;
            end
            S_CMP_MIN: begin
                sel_d  = {2'b00, cand_min_d, step_d};
                busy_d = 1'b1;
            end
            S_FINISH: begin
                done_d    = 1'b1;
                max_idx_d = cand_max_d;
                min_idx_d = cand_min_d;
            end
            default: begin
            end
        endcase
    end

    assign slv_bus.sel = sel_q;
    assign slv_bus.ld  = ld_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign max_idx_o   = max_idx_q;
    assign min_idx_o   = min_idx_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_master_circuit.sv
// tb/tb_master_circuit.sv - scoreboard bench for master_circuit with behavioural slave models
module tb_master_circuit;

    typedef struct {
        logic [1:0] mx;
        logic [1:0] mn;
        logic       er;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start1, skip1, start3, skip3;
    logic busy1, done1, err1, busy3, done3, err3;
    logic [1:0] max1, min1, max3, min3;
    logic inject;
    int   cyc;
    int   n_tests;
    int   n_fail;

    exp_t q1[$];
    exp_t q3[$];

    logic [3:0] src1 [4];
    logic [3:0] src3 [4];
    logic [3:0] regs1 [4];
    logic [3:0] regs3 [4];
    logic [2:0] raw1, raw3, d1_3, d2_3;
    logic [3:0] a1, b1, a3, b3;

    master_circuit_if bus1 ();
    master_circuit_if bus3 ();

    master_circuit #(.SETTLE(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .skip_load_i(skip1),
        .slv_bus(bus1), .busy_o(busy1), .done_o(done1),
        .max_idx_o(max1), .min_idx_o(min1), .err_o(err1)
    );

    master_circuit #(.SETTLE(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start3), .skip_load_i(skip3),
        .slv_bus(bus3), .busy_o(busy3), .done_o(done3),
        .max_idx_o(max3), .min_idx_o(min3), .err_o(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave models: registers load from the source selected by sel[5:4].
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus1.ld[k]) regs1[k] <= src1[bus1.sel[5:4]];
            if (bus3.ld[k]) regs3[k] <= src3[bus3.sel[5:4]];
        end
        d1_3 <= raw3;
        d2_3 <= d1_3;
    end

    assign a1   = regs1[bus1.sel[1:0]];
    assign b1   = regs1[bus1.sel[3:2]];
    assign raw1 = {a1 > b1, a1 == b1, a1 < b1};
    // Corrupt only the pattern of the second max step (A=2, B=cand 1).
    assign bus1.lt = (inject && busy1 && bus1.ld == 4'b0000 && bus1.sel[3:0] == 4'b0110)
                     ? 3'b011 : raw1;

    assign a3   = regs3[bus3.sel[1:0]];
    assign b3   = regs3[bus3.sel[3:2]];
    assign raw3 = {a3 > b3, a3 == b3, a3 < b3};
    assign bus3.lt = d2_3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever a DUT pulses done.
    logic [5:0] prev_sel3;
    logic       prev_cmp3;
    int         run3;
    always @(negedge clk) begin : monitor
        exp_t e;
        logic c3;
        if (rst_n) begin
            if (done1) begin
                if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("dut1_max_idx", max1, e.mx);
                    chk("dut1_min_idx", min1, e.mn);
                    chk("dut1_err_at_done", err1, e.er);
                    chk("dut1_done_cycle", cyc, e.cyc);
                end
            end
            if (done3) begin
                if (q3.size() == 0) chk("dut3_unexpected_done", 1, 0);
                else begin
                    e = q3.pop_front();
                    chk("dut3_max_idx", max3, e.mx);
                    chk("dut3_min_idx", min3, e.mn);
                    chk("dut3_err_at_done", err3, e.er);
                    chk("dut3_done_cycle", cyc, e.cyc);
                end
            end
            // Each compare pattern on dut3 must be held exactly SETTLE=3 cycles.
            c3 = busy3 && (bus3.ld == 4'b0000);
            if (prev_cmp3 && !(c3 && bus3.sel == prev_sel3)) chk("dut3_sel_hold", run3, 3);
            run3      <= (c3 && prev_cmp3 && bus3.sel == prev_sel3) ? run3 + 1 : (c3 ? 1 : 0);
            prev_cmp3 <= c3;
            prev_sel3 <= bus3.sel;
        end
    end

    task automatic start_run(input int d, input logic skip,
                             input logic [3:0] v0, input logic [3:0] v1,
                             input logic [3:0] v2, input logic [3:0] v3,
                             input logic [1:0] mx, input logic [1:0] mn,
                             input logic er, input int lat);
        exp_t e;
        @(negedge clk);
        e.mx = mx; e.mn = mn; e.er = er; e.cyc = cyc + 1 + lat - 1;
        if (d == 1) begin
            src1[0] = v0; src1[1] = v1; src1[2] = v2; src1[3] = v3;
            skip1 = skip; start1 = 1'b1; q1.push_back(e);
        end else begin
            src3[0] = v0; src3[1] = v1; src3[2] = v2; src3[3] = v3;
            skip3 = skip; start3 = 1'b1; q3.push_back(e);
        end
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", q1.size() + q3.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int acc;
        logic [3:0] one;
        exp_t e;
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; inject = 1'b0;
        start1 = 1'b0; skip1 = 1'b0; start3 = 1'b0; skip3 = 1'b0;
        prev_cmp3 = 1'b0; run3 = 0; prev_sel3 = 6'd0;
        repeat (3) @(negedge clk);
        chk("rst_sel", bus1.sel, 0);
        chk("rst_ld", bus1.ld, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_max", max1, 0);
        chk("rst_min", min1, 0);
        chk("rst_err", err1, 0);
        chk("rst_busy3", busy3, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy1, 0);

        // Reset while loading k=2: outputs drop at once, no done follows.
        @(negedge clk);
        src1[0] = 4'd3; src1[1] = 4'd9; src1[2] = 4'd9; src1[3] = 4'd1;
        skip1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (bus1.ld != 4'b0100 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reach_load_k2", bus1.ld, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ld", bus1.ld, 0);
        chk("midrst_sel", bus1.sel, 0);
        chk("midrst_busy", busy1, 0);
        chk("midrst_done", done1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full run {3,9,9,1}: tie on max keeps index 1.
        start_run(1, 1'b0, 4'd3, 4'd9, 4'd9, 4'd1, 2'd1, 2'd3, 1'b0, 11);
        for (int k = 0; k < 4; k++) begin
            one = 4'b0001 << k;
            chk("load_ld_onehot", bus1.ld, one);
            chk("load_src_idx", bus1.sel[5:4], k);
            chk("load_mux_idx", bus1.sel[3:0], 0);
            chk("load_busy", busy1, 1);
            @(negedge clk);
        end
        wait_idle(100);

        // Load all sevens, then compare them again without loading.
        start_run(1, 1'b0, 4'd7, 4'd7, 4'd7, 4'd7, 2'd0, 2'd0, 1'b0, 11);
        wait_idle(100);
        start_run(1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 2'd0, 1'b0, 7);
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus1.ld != 4'b0000) acc++;
            @(negedge clk);
        end
        chk("skip_no_ld", acc, 0);
        wait_idle(100);

        // Bad lt on second max step: candidate stays 1 (would be 2), err sticky.
        inject = 1'b1;
        start_run(1, 1'b0, 4'd1, 4'd5, 4'd9, 4'd2, 2'd1, 2'd0, 1'b1, 11);
        wait_idle(100);
        inject = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_sticky", err1, 1);
        start_run(1, 1'b0, 4'd4, 4'd2, 4'd8, 4'd6, 2'd2, 2'd1, 1'b0, 11);
        chk("err_cleared_on_start", err1, 0);
        wait_idle(100);

        // START held: second run accepted on the IDLE cycle after done.
        @(negedge clk);
        src1[0] = 4'd4; src1[1] = 4'd2; src1[2] = 4'd8; src1[3] = 4'd6;
        skip1 = 1'b0; start1 = 1'b1;
        n = cyc + 1;
        e.mx = 2'd2; e.mn = 2'd1; e.er = 1'b0; e.cyc = n + 10;
        q1.push_back(e);
        e.cyc = n + 12 + 10;
        q1.push_back(e);
        while (cyc < n + 11) @(negedge clk);
        chk("b2b_idle_busy", busy1, 0);
        chk("b2b_idle_ld", bus1.ld, 0);
        chk("b2b_idle_done", done1, 0);
        @(negedge clk);
        chk("b2b_restart_ld", bus1.ld, 4'b0001);
        start1 = 1'b0;
        wait_idle(100);

        // START pulsed while busy is ignored.
        start_run(1, 1'b0, 4'd4, 4'd2, 4'd8, 4'd6, 2'd2, 2'd1, 1'b0, 11);
        repeat (3) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_idle(100);
        repeat (15) @(negedge clk);
        chk("pulse_ignored_busy", busy1, 0);

        // SETTLE=3 with lt delayed two cycles.
        start_run(3, 1'b0, 4'd2, 4'd5, 4'd0, 4'd8, 2'd3, 2'd2, 1'b0, 23);
        wait_idle(200);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
